// File: rtl/c880_bist_pkg.sv
// Shared constants, state encoding and pattern/signature step functions
// for the c880 BIST controller.
package c880_bist_pkg;

  localparam int IN_W  = 60;
  localparam int OUT_W = 26;

  localparam int LFSR_TAP_HI = 59;
  localparam int LFSR_TAP_LO = 58;
  localparam logic [OUT_W-1:0] MISR_POLY = 26'h0000047;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Fibonacci LFSR step for x^60 + x^59 + 1.
  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] cur);
    return {cur[IN_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
  endfunction

  // Galois MISR step, used to predict the signature one edge ahead.
  function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] cur,
                                                input logic [OUT_W-1:0] din);
    logic [OUT_W-1:0] fb;
    fb = cur[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}};
    return {cur[OUT_W-2:0], 1'b0} ^ fb ^ din;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Galois-form multiple-input signature register with synchronous clear
// and capture enable.
module bist_misr #(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(7'h47)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] fb;

  // Feedback polynomial is folded in only when the MSB shifts out.
  always_comb begin
    fb = {WIDTH{1'b0}};
    if (sig[WIDTH-1]) begin
      fb = POLY;
    end else begin
      fb = {WIDTH{1'b0}};
    end
  end

  // Signature register: clear wins over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= {WIDTH{1'b0}};
    end else if (clr) begin
      sig <= {WIDTH{1'b0}};
    end else if (en) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/c880_bist_ctrl.sv
// BIST controller for the c880 CUT: LFSR pattern source, settle timing,
// MISR compaction and end-of-run golden-signature comparison.
module c880_bist_ctrl
  import c880_bist_pkg::*;
#(
  parameter int NUM_PATTERNS = 10,
  parameter int SETTLE_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  seed_in,
  input  logic [OUT_W-1:0] golden_sig,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      pattern_idx
);

  if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_num_patterns
    $error("c880_bist_ctrl: NUM_PATTERNS must be in 1..65535");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("c880_bist_ctrl: SETTLE_CYC must be in 1..15");
  end

  localparam logic [15:0] LAST_IDX   = 16'(NUM_PATTERNS - 1);
  localparam logic [3:0]  SETTLE_INI = 4'(SETTLE_CYC - 1);

  state_t            state_r;
  state_t            state_nxt;
  logic [IN_W-1:0]   lfsr_r;
  logic [OUT_W-1:0]  golden_r;
  logic [3:0]        settle_cnt_r;
  logic              start_ok;
  logic              last_pat;
  logic              capture_en;

  // Next-state decode and control strobes.
  always_comb begin
    state_nxt  = state_r;
    start_ok   = 1'b0;
    last_pat   = (pattern_idx == LAST_IDX);
    capture_en = (state_r == ST_CAPTURE);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = ST_APPLY;
        end else begin
          state_nxt = state_r;
        end
      end
      ST_APPLY: begin
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_r == 4'd0) begin
          state_nxt = ST_CAPTURE;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        if (last_pat) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_APPLY;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pattern source, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      lfsr_r       <= {IN_W{1'b0}};
      golden_r     <= {OUT_W{1'b0}};
      settle_cnt_r <= 4'd0;
      cut_in       <= {IN_W{1'b0}};
      pattern_idx  <= 16'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state_r <= state_nxt;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            // An all-zero seed would lock the LFSR at zero forever.
            lfsr_r      <= (seed_in == {IN_W{1'b0}}) ? IN_W'(1'b1) : seed_in;
            golden_r    <= golden_sig;
            pattern_idx <= 16'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
          end
        end
        ST_APPLY: begin
          cut_in       <= lfsr_r;
          settle_cnt_r <= SETTLE_INI;
        end
        ST_SETTLE: begin
          if (settle_cnt_r != 4'd0) begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        ST_CAPTURE: begin
          lfsr_r <= lfsr_next(lfsr_r);
          if (last_pat) begin
            busy <= 1'b0;
            done <= 1'b1;
            // Compare against the signature the MISR is loading on this edge.
            pass <= (misr_next(signature, cut_out) == golden_r);
          end else begin
            pattern_idx <= pattern_idx + 16'd1;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  bist_misr #(
    .WIDTH (OUT_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (capture_en),
    .din (cut_out),
    .sig (signature)
  );

endmodule

// File: tb/tb_c880_bist_ctrl.sv
// Self-checking bench for c880_bist_ctrl: scoreboarded vectors, indices and
// signatures checked cycle by cycle against a reference LFSR/MISR model.
module tb_c880_bist_ctrl;

  localparam int NP = 4;
  localparam int SC = 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic [59:0] seed_in;
  logic [25:0] golden_sig;
  logic [59:0] cut_in;
  logic [25:0] cut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [25:0] signature;
  logic [15:0] pattern_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] resp_tbl [NP];
  logic [25:0] sig_hist [NP];
  logic [59:0] vec_hist [NP];

  logic [59:0] exp_vec_q [$];
  logic [15:0] exp_idx_q [$];
  logic [25:0] exp_sig_q [$];

  c880_bist_ctrl #(.NUM_PATTERNS(NP), .SETTLE_CYC(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed_in     (seed_in),
    .golden_sig  (golden_sig),
    .cut_in      (cut_in),
    .cut_out     (cut_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature),
    .pattern_idx (pattern_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] ref_lfsr(input logic [59:0] v);
    logic nb;
    nb = v[59] ^ v[58];
    return {v[58:0], nb};
  endfunction

  function automatic logic [25:0] ref_misr(input logic [25:0] m, input logic [25:0] d);
    logic [25:0] r;
    r = {m[24:0], 1'b0};
    if (m[25]) r = r ^ 26'h0000047;
    return r ^ d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, pass} !== 3'b000 || signature !== 26'h0 || cut_in !== 60'h0 || pattern_idx !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b sig=%h cut_in=%h idx=%0d, expected all zero",
               busy, done, pass, signature, cut_in, pattern_idx);
    end
    rst = 1'b0;
  endtask

  // One full run: the model fills the scoreboard, the DUT drains it.
  task automatic run_check(input logic [59:0] seed, input logic [25:0] gold, input int poke_pat);
    logic [59:0] lf;
    logic [25:0] m;
    logic        exp_pass;
    logic [59:0] vec;
    logic [15:0] idx;
    logic [25:0] esig;
    int          cycles;

    lf = (seed == 60'h0) ? 60'h1 : seed;
    m  = 26'h0;
    for (int k = 0; k < NP; k++) begin
      exp_vec_q.push_back(lf);
      exp_idx_q.push_back(16'(k));
      m = ref_misr(m, resp_tbl[k]);
      exp_sig_q.push_back(m);
      lf = ref_lfsr(lf);
    end
    exp_pass = (m == gold);

    @(negedge clk);
    start = 1'b1;
    seed_in = seed;
    golden_sig = gold;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seed_in = {$urandom(), $urandom()};
    golden_sig = 26'($urandom());
    cycles = 1;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b done=%b pass=%b, expected 1 0 0", busy, done, pass);
    end

    for (int k = 0; k < NP; k++) begin
      cut_out = 26'($urandom());
      @(posedge clk);
      @(negedge clk);
      cycles++;
      vec = exp_vec_q.pop_front();
      idx = exp_idx_q.pop_front();
      vec_hist[k] = cut_in;
      n_checks++;
      if (cut_in !== vec || pattern_idx !== idx) begin
        n_fail++;
        $display("FAIL apply_vec pat %0d: cut_in=%h idx=%0d, expected %h idx=%0d", k, cut_in, pattern_idx, vec, idx);
      end
      for (int s = 0; s < SC; s++) begin
        if (k == poke_pat && s == 0) start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cycles++;
        n_checks++;
        if (cut_in !== vec || pattern_idx !== idx || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL settle_hold pat %0d: cut_in=%h idx=%0d busy=%b, expected %h idx=%0d busy=1",
                   k, cut_in, pattern_idx, busy, vec, idx);
        end
      end
      cut_out = resp_tbl[k];
      @(posedge clk);
      @(negedge clk);
      cut_out = 26'($urandom());
      cycles++;
      esig = exp_sig_q.pop_front();
      sig_hist[k] = signature;
      n_checks++;
      if (signature !== esig || cut_in !== vec) begin
        n_fail++;
        $display("FAIL capture_sig pat %0d: sig=%h cut_in=%h, expected sig=%h cut_in=%h", k, signature, cut_in, esig, vec);
      end
      if (k == NP - 1) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || cycles != NP * (SC + 2) + 1) begin
          n_fail++;
          $display("FAIL done_state: done=%b busy=%b pass=%b cycles=%0d, expected 1 0 %b cycles=%0d",
                   done, busy, pass, cycles, exp_pass, NP * (SC + 2) + 1);
        end
      end else begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_run_flags pat %0d: done=%b busy=%b, expected 0 1", k, done, busy);
        end
      end
    end

    // DONE holds its results while the CUT response wanders.
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || signature !== m || cut_in !== vec || pass !== exp_pass) begin
      n_fail++;
      $display("FAIL done_hold: done=%b sig=%h cut_in=%h pass=%b, expected 1 %h %h %b",
               done, signature, cut_in, pass, m, vec, exp_pass);
    end
  endtask

  task automatic test_pattern_sequence();
    for (int k = 0; k < NP; k++) resp_tbl[k] = 26'h0;
    run_check(60'h1, 26'h0, -1);
    n_checks++;
    if (vec_hist[0] !== 60'h1 || vec_hist[1] !== 60'h2 || vec_hist[2] !== 60'h4 || vec_hist[3] !== 60'h8) begin
      n_fail++;
      $display("FAIL pattern_seq: got %h %h %h %h, expected 1 2 4 8", vec_hist[0], vec_hist[1], vec_hist[2], vec_hist[3]);
    end
  endtask

  task automatic test_zero_seed();
    for (int k = 0; k < NP; k++) resp_tbl[k] = 26'($urandom());
    run_check(60'h0, 26'($urandom()), -1);
    n_checks++;
    if (vec_hist[0] !== 60'h1) begin
      n_fail++;
      $display("FAIL zero_seed: first cut_in=%h, expected 1", vec_hist[0]);
    end
  endtask

  task automatic test_misr_arith();
    for (int k = 0; k < NP; k++) resp_tbl[k] = 26'h1;
    run_check(60'h123456789ABCDEF, 26'h000000F, -1);
    n_checks++;
    if (sig_hist[1] !== 26'h3 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL misr_arith: sig after 2 captures=%h pass=%b, expected 3 1", sig_hist[1], pass);
    end
    run_check(60'h123456789ABCDEF, 26'h0000002, -1);
    n_checks++;
    if (pass !== 1'b0) begin
      n_fail++;
      $display("FAIL misr_golden_mismatch: pass=%b, expected 0", pass);
    end
  endtask

  task automatic test_poly_feedback();
    resp_tbl[0] = 26'h2000000;
    for (int k = 1; k < NP; k++) resp_tbl[k] = 26'h0;
    run_check(60'hFEDCBA987654321, 26'h0, -1);
    n_checks++;
    if (sig_hist[0] !== 26'h2000000 || sig_hist[1] !== 26'h0000047) begin
      n_fail++;
      $display("FAIL poly_feedback: sig=%h then %h, expected 2000000 then 0000047", sig_hist[0], sig_hist[1]);
    end
  endtask

  task automatic test_start_while_busy();
    for (int k = 0; k < NP; k++) resp_tbl[k] = 26'($urandom());
    run_check({$urandom(), $urandom()}, 26'($urandom()), 1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NP; k++) resp_tbl[k] = 26'($urandom());
    run_check(60'hA5A5A5A5A5A5A5A, 26'($urandom()), -1);
    run_check(60'h1, 26'($urandom()), -1);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    seed_in = 60'h1;
    cut_out = 26'h3FFFFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2 * (SC + 2) + 1) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || pattern_idx !== 16'd2 || cut_in !== 60'h4) begin
      n_fail++;
      $display("FAIL pre_reset_settle: busy=%b idx=%0d cut_in=%h, expected 1 2 4", busy, pattern_idx, cut_in);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || signature !== 26'h0 || cut_in !== 60'h0 || pattern_idx !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b sig=%h cut_in=%h idx=%0d, expected all zero",
               busy, done, signature, cut_in, pattern_idx);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cut_in !== 60'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b cut_in=%h, expected 0 0 0", busy, done, cut_in);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    seed_in = 60'h0;
    golden_sig = 26'h0;
    cut_out = 26'h0;
    test_reset();
    test_pattern_sequence();
    test_zero_seed();
    test_misr_arith();
    test_poly_feedback();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
